// File: rtl/pc_fetch_unit.sv
// PC register, next-PC select and virtual->ROM word index translation with a latched fault record.
// Optional build macro PCU_EXC_VECTOR_EN: faults redirect to EXC_VECTOR instead of halting in FAULT.
module pc_fetch_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h00400000,
  parameter int          ADDR_BITS  = 10,
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h00400180
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branchTaken,
  input  logic [31:0]          branchTarget,
  input  logic                 jump,
  input  logic [31:0]          jumpTarget,
  input  logic                 faultClear,
  output logic [31:0]          virtualPC,
  output logic [ADDR_BITS-1:0] physicalPC,
  output logic                 invalidPC,
  output logic                 fetchEn,
  output logic                 faultValid,
  output logic [31:0]          faultPC,
  output logic [1:0]           faultCause,
  output logic                 faultOverrun
);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_BITS) - 33'd1;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_fv, w_fv_nxt;
  logic [31:0] r_fpc, w_fpc_nxt;
  logic [1:0]  r_cause, w_cause_nxt;
  logic        r_ovr, w_ovr_nxt;

  logic        w_range, w_misal, w_bad, w_detect;

  // 33-bit compare so addresses near 2^32 cannot wrap into the region.
  assign w_range  = ({1'b0, r_pc} < {1'b0, BASE_ADDR}) | ({1'b0, r_pc} > LIMIT);
  assign w_misal  = |r_pc[1:0];
  assign w_bad    = w_range | w_misal;
  assign w_detect = (r_state == ST_RUN) & w_bad;

  assign virtualPC    = r_pc;
  assign physicalPC   = r_pc[ADDR_BITS+1:2] - BASE_ADDR[ADDR_BITS+1:2];
  assign invalidPC    = w_bad | (r_state == ST_FAULT);
  assign fetchEn      = (r_state == ST_RUN) & ~w_bad;
  assign faultValid   = r_fv;
  assign faultPC      = r_fpc;
  assign faultCause   = r_cause;
  assign faultOverrun = r_ovr;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fv_nxt    = r_fv;
    w_fpc_nxt   = r_fpc;
    w_cause_nxt = r_cause;
    w_ovr_nxt   = r_ovr;

    // A clear arriving with a new fault lets the new fault reload the record.
    if (w_detect) begin
      if (r_fv && !faultClear) begin
        w_ovr_nxt = 1'b1;
      end else begin
        w_fv_nxt    = 1'b1;
        w_fpc_nxt   = r_pc;
        w_cause_nxt = {w_misal, w_range};
        w_ovr_nxt   = 1'b0;
      end
    end else if (faultClear && r_fv) begin
      w_fv_nxt    = 1'b0;
      w_cause_nxt = 2'b00;
      w_ovr_nxt   = 1'b0;
    end

    case (r_state)
      ST_RUN: begin
        if (w_detect) begin
`ifdef PCU_EXC_VECTOR_EN
          w_pc_nxt = EXC_VECTOR;
`else
          w_state_nxt = ST_FAULT;
`endif
        end else if (!stall) begin
          if (jump)             w_pc_nxt = jumpTarget;
          else if (branchTaken) w_pc_nxt = branchTarget;
          else                  w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_FAULT: begin
        if (faultClear && r_fv) begin
          w_pc_nxt    = RESET_PC;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_fv    <= 1'b0;
      r_fpc   <= 32'd0;
      r_cause <= 2'b00;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fv    <= w_fv_nxt;
      r_fpc   <= w_fpc_nxt;
      r_cause <= w_cause_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

endmodule
